// File: rtl/vga_board_adapter.sv
// Board-level adapter for a TinyTapeout-style VGA demo core: divides the
// board clock into the core clock, stretches the core reset (system reset or
// debounced button), and drives registered, remapped, blank-gated VGA pins.
module vga_board_adapter #(
    parameter int DIV             = 2,
    parameter int RST_CYCLES      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PIN_MODE        = 0,
    parameter int HS_INVERT       = 0,
    parameter int VS_INVERT       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [7:0] uo_out,
    output logic       core_clk,
    output logic       core_tick,
    output logic       core_rst_n,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int DIV_W = $clog2(DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [DIV_W-1:0] TICK_AT  = DIV_W'(DIV / 2 - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);

    // Deasserted sync levels; also what the pins show while blanked.
    localparam logic HS_IDLE = 1'(HS_INVERT);
    localparam logic VS_IDLE = 1'(VS_INVERT);

    // ------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             core_clk_q, core_tick_q;

    // Next divider count, wrapping at DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // Divider state; core_clk and core_tick are decoded from the next count
    // so both flops stay aligned with the count they describe.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and
        // is not in the sensitivity list; all state updates use <= so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            div_q       <= '0;
            core_clk_q  <= 1'b0;
            core_tick_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            core_clk_q  <= (div_d >= DIV_HALF);
            core_tick_q <= (div_d == TICK_AT);
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer (level 1 = released)
    // ------------------------------------------------------------------
    logic [1:0]      sync_q;
    logic            btn_sync;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;

    assign btn_sync = sync_q[1];

    // Debounce: count while the synced level disagrees, flip when it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_sync != deb_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_d = btn_sync;
            end else begin
                deb_cnt_d = deb_cnt_q + DB_W'(1);
            end
        end
    end

    // Synchronizer and debounce state; both start in the released state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_n};
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Core reset stretcher
    // ------------------------------------------------------------------
    logic             cause;
    logic [RST_W-1:0] hold_q, hold_d;
    logic             core_rst_n_q;

    // The cause covers the flip cycle (deb_d) so the core reset asserts on
    // the same edge the debounced state goes pressed, and the settled state
    // (deb_q) so the countdown starts only once it reads released.
    assign cause = !rst_n || !deb_q || !deb_d;

    // Hold counter: reload while any cause is active, else count down to 0.
    always_comb begin
        hold_d = hold_q;
        if (cause) begin
            hold_d = RST_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - RST_W'(1);
        end
    end

    // Hold counter and core reset flop; core_rst_n rises as hold hits 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= RST_LOAD;
            core_rst_n_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            core_rst_n_q <= (hold_d == '0);
        end
    end

    // ------------------------------------------------------------------
    // Pin stage
    // ------------------------------------------------------------------
    logic [1:0] pin_r, pin_g, pin_b;
    logic       pin_hs, pin_vs;
    logic [1:0] vga_r_q, vga_g_q, vga_b_q;
    logic       vga_hs_q, vga_vs_q;

    // Unpack colour and sync fields from the core output byte.
    always_comb begin
        if (PIN_MODE == 0) begin
            pin_hs = uo_out[7];
            pin_vs = uo_out[3];
            pin_r  = {uo_out[0], uo_out[4]};
            pin_g  = {uo_out[1], uo_out[5]};
            pin_b  = {uo_out[2], uo_out[6]};
        end else begin
            pin_hs = uo_out[7];
            pin_vs = uo_out[6];
            pin_b  = uo_out[5:4];
            pin_g  = uo_out[3:2];
            pin_r  = uo_out[1:0];
        end
    end

    // Register the pins, blanking while the core is held in reset.
    always_ff @(posedge clk) begin
        if (!rst_n || !core_rst_n_q) begin
            vga_r_q  <= 2'b00;
            vga_g_q  <= 2'b00;
            vga_b_q  <= 2'b00;
            vga_hs_q <= HS_IDLE;
            vga_vs_q <= VS_IDLE;
        end else begin
            vga_r_q  <= pin_r;
            vga_g_q  <= pin_g;
            vga_b_q  <= pin_b;
            vga_hs_q <= pin_hs ^ HS_IDLE;
            vga_vs_q <= pin_vs ^ VS_IDLE;
        end
    end

    assign core_clk   = core_clk_q;
    assign core_tick  = core_tick_q;
    assign core_rst_n = core_rst_n_q;
    assign vga_r      = vga_r_q;
    assign vga_g      = vga_g_q;
    assign vga_b      = vga_b_q;
    assign vga_hs     = vga_hs_q;
    assign vga_vs     = vga_vs_q;

endmodule
